// File: rtl/eth_frame_loop_pkg.sv
// Shared types and constants for the single-clock store-and-forward frame loop buffer.
package eth_frame_loop_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_RECV = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

    localparam int STAT_W = 32;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/eth_frame_loop_buffer_if.sv
// AXI4-Stream bundle used for both the receive (slave) and transmit (master) sides.
interface eth_frame_loop_buffer_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_frame_loop_ram.sv
// Simple dual-port RAM: one write port, one registered read port; maps onto block RAM.
module eth_frame_loop_ram
    import eth_frame_loop_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2048,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array and read register are deliberately not reset (block RAM cannot be);
    // sequential state is always assigned with <= so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/eth_frame_loop_buffer.sv
// Store-and-forward frame loop buffer: forwards only complete, error-free frames that fit.
// Optional ETH_FRAME_LOOP_STATS_EN adds saturating forwarded/dropped frame counters.
module eth_frame_loop_buffer
    import eth_frame_loop_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    eth_frame_loop_buffer_if.slave  s_axis,
    eth_frame_loop_buffer_if.master m_axis,
    output logic                   frame_drop
`ifdef ETH_FRAME_LOOP_STATS_EN
    ,
    output logic [STAT_W-1:0]      stat_frames_fwd,
    output logic [STAT_W-1:0]      stat_frames_drop
`endif
);
    localparam int AW = addr_width(DEPTH);
    localparam int RW = DATA_WIDTH + 1;
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(DEPTH);

    wr_state_e   state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        bad_q, bad_d, frame_drop_q, drop_d;
    logic        wr_en, commit_en, full;
    logic [AW:0] used;

    // Space is judged on registered pointers only; a same-cycle read frees nothing.
    assign used = wr_ptr_q - rd_ptr_q;
    assign full = (used == PTR_DEPTH);
    assign s_axis.tready = 1'b1;

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        bad_d        = bad_q;
        drop_d       = 1'b0;
        wr_en        = 1'b0;
        commit_en    = 1'b0;
        if (s_axis.tvalid) begin
            case (state_q)
                WR_IDLE, WR_RECV: begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        bad_d    = 1'b0;
                        if (s_axis.tlast) begin
                            drop_d  = 1'b1;
                            state_d = WR_IDLE;
                        end else begin
                            state_d = WR_DROP;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (s_axis.tlast) begin
                            bad_d   = 1'b0;
                            state_d = WR_IDLE;
                            if (bad_q || s_axis.tuser) begin
                                wr_ptr_d = commit_ptr_q;
                                drop_d   = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + PTR_ONE;
                                commit_en    = 1'b1;
                            end
                        end else begin
                            bad_d   = bad_q | s_axis.tuser;
                            state_d = WR_RECV;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis.tlast) begin
                        drop_d  = 1'b1;
                        state_d = WR_IDLE;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            bad_q        <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            bad_q        <= bad_d;
            frame_drop_q <= drop_d;
        end
    end

    assign frame_drop = frame_drop_q;

    logic          rd_issue, rd_valid_q, pop;
    logic [RW-1:0] ram_rdata;
    logic [1:0]    occ, occ_after;
    logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [RW-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;

    eth_frame_loop_ram #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({s_axis.tlast, s_axis.tdata}),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // A read is issued only if the beat it returns is guaranteed a slot in output or skid.
    assign pop       = out_valid_q & m_axis.tready;
    assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q};
    assign occ_after = occ - {1'b0, pop};
    assign rd_issue  = (rd_ptr_q != commit_ptr_q) && (occ_after < 2'd2);
    assign rd_ptr_d  = rd_issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = rd_valid_q;
                skid_data_d  = ram_rdata;
            end else begin
                out_valid_d = rd_valid_q;
                if (rd_valid_q) out_data_d = ram_rdata;
            end
        end else if (rd_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= rd_issue;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_data_q[DATA_WIDTH-1:0];
    assign m_axis.tlast  = out_data_q[DATA_WIDTH];
    assign m_axis.tuser  = 1'b0;

`ifdef ETH_FRAME_LOOP_STATS_EN
    logic [STAT_W-1:0] stat_fwd_q, stat_drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_fwd_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            if (commit_en && stat_fwd_q != '1) stat_fwd_q <= stat_fwd_q + STAT_W'(1);
            if (drop_d && stat_drop_q != '1) stat_drop_q <= stat_drop_q + STAT_W'(1);
        end
    end

    assign stat_frames_fwd  = stat_fwd_q;
    assign stat_frames_drop = stat_drop_q;
`endif
endmodule
